// File: rtl/demux1to4_framer_if.sv
// TDM word input and assembled-frame output of the 1:4 demux framer.
// master drives the TDM stream and consumes frames; slave is the framer.
interface demux1to4_framer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_sof;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_d;
  logic               frame_valid;
  logic               frame_ready;
  logic [3:0]         ch_strobe;
  logic               sync_err;

  modport master (
    output in_data, in_valid, in_sof, frame_ready,
    input  in_ready, out_d, frame_valid, ch_strobe, sync_err
  );

  modport slave (
    input  in_data, in_valid, in_sof, frame_ready,
    output in_ready, out_d, frame_valid, ch_strobe, sync_err
  );
endinterface

// File: rtl/demux1to4_framer.sv
// 1:4 TDM demux + frame assembler; frame valid 1 cycle after the slot-3 accept.
// in_ready drops only when the slot-3 word would overwrite an unconsumed frame.
module demux1to4_framer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  demux1to4_framer_if.slave     bus
);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               slot_q, slot_d;
  logic [2:0][WIDTH-1:0]    lanes_q;
  logic [4*WIDTH-1:0]       out_d_q;
  logic                     frame_valid_q;
  logic [3:0]               ch_strobe_q;
  logic                     sync_err_q;

  logic                     accept;
  logic                     lane_wr;
  logic [1:0]               lane_idx;
  logic                     load_frame;
  logic                     err;

  assign accept = bus.in_valid & bus.in_ready;

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      lanes_q       <= '0;
      out_d_q       <= '0;
      frame_valid_q <= 1'b0;
      ch_strobe_q   <= 4'b0000;
      sync_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sync_err_q  <= err;
      ch_strobe_q <= lane_wr ? (4'b0001 << lane_idx) : 4'b0000;
      if (lane_wr && lane_idx != 2'd3) begin
        lanes_q[lane_idx] <= bus.in_data;
      end
      if (load_frame) begin
        out_d_q       <= {bus.in_data, lanes_q[2], lanes_q[1], lanes_q[0]};
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && bus.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  // Next-state: slot tracking, lane steering and framing-error detection.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    lane_wr    = 1'b0;
    lane_idx   = slot_q;
    load_frame = 1'b0;
    err        = 1'b0;
    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            lane_wr  = 1'b1;
            lane_idx = 2'd0;
            slot_d   = 2'd1;
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.in_sof) begin
            // A marker mid-frame restarts assembly; the partial frame is lost.
            err      = (slot_q != 2'd0);
            lane_wr  = 1'b1;
            lane_idx = 2'd0;
            slot_d   = 2'd1;
          end else if (slot_q == 2'd0) begin
            err     = 1'b1;
            state_d = HUNT;
          end else begin
            lane_wr = 1'b1;
            if (slot_q == 2'd3) begin
              load_frame = 1'b1;
              slot_d     = 2'd0;
            end else begin
              slot_d = slot_q + 2'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.in_ready    = rst | ~((state_q == COLLECT) && (slot_q == 2'd3) && !bus.in_sof &&
                              frame_valid_q && !bus.frame_ready);
    bus.out_d       = out_d_q;
    bus.frame_valid = frame_valid_q;
    bus.ch_strobe   = ch_strobe_q;
    bus.sync_err    = sync_err_q;
  end

endmodule

// File: tb/tb_demux1to4_framer.sv
// Bench for demux1to4_framer: directed scenarios plus random traffic vs a frame-level model.
module tb_demux1to4_framer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux1to4_framer_if #(.WIDTH(W)) bus ();
  demux1to4_framer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Model: words of the frame being gathered, plus whether a marker is expected.
  bit             m_in_frame;
  logic [W-1:0]   m_part[$];
  bit             m_have;
  logic [4*W-1:0] m_frame;
  logic [3:0]     e_strobe;
  bit             e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit s, input logic [W-1:0] d, input bit fr);
    bit rdy, acc, consumed, load;
    logic [4*W-1:0] nf;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.in_sof = s; bus.in_data = d; bus.frame_ready = fr;
    #1;
    rdy = r || !(m_in_frame && m_part.size() == 3 && !s && m_have && !fr);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
    e_strobe = 4'b0000; e_err = 1'b0; load = 1'b0; nf = '0;
    if (r) begin
      m_in_frame = 1'b0; m_part.delete(); m_have = 1'b0; m_frame = '0;
    end else begin
      acc = v && rdy;
      consumed = m_have && fr;
      if (acc) begin
        if (s) begin
          if (m_in_frame && m_part.size() != 0) e_err = 1'b1;
          m_in_frame = 1'b1;
          m_part.delete();
          m_part.push_back(d);
          e_strobe = 4'b0001;
        end else if (m_in_frame) begin
          if (m_part.size() == 0) begin
            e_err = 1'b1;
            m_in_frame = 1'b0;
          end else begin
            e_strobe = 4'b0001 << m_part.size();
            if (m_part.size() == 3) begin
              nf = {d, m_part[2], m_part[1], m_part[0]};
              load = 1'b1;
              m_part.delete();
            end else begin
              m_part.push_back(d);
            end
          end
        end
      end
      if (load) begin m_have = 1'b1; m_frame = nf; end
      else if (consumed) m_have = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("frame_valid", {31'd0, bus.frame_valid}, {31'd0, m_have});
    chk("out_d", bus.out_d, m_frame);
    chk("ch_strobe", {28'd0, bus.ch_strobe}, {28'd0, e_strobe});
    chk("sync_err", {31'd0, bus.sync_err}, {31'd0, e_err});
  endtask

  task automatic word(input bit s, input logic [W-1:0] d, input bit fr);
    cycle(1'b0, 1'b1, s, d, fr);
  endtask

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0; bus.frame_ready = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_out_d", bus.out_d, 32'h0);

    // Basic frame and strobe walk.
    word(1'b1, 8'h11, 1'b1); chk("strobe0", {28'd0, bus.ch_strobe}, 32'h1);
    word(1'b0, 8'h22, 1'b1); chk("strobe1", {28'd0, bus.ch_strobe}, 32'h2);
    word(1'b0, 8'h33, 1'b1); chk("strobe2", {28'd0, bus.ch_strobe}, 32'h4);
    word(1'b0, 8'h44, 1'b0); chk("strobe3", {28'd0, bus.ch_strobe}, 32'h8);
    chk("frame1", bus.out_d, 32'h44332211);

    // Second frame stalls on its last word until the first is taken.
    word(1'b1, 8'h55, 1'b0);
    word(1'b0, 8'h66, 1'b0);
    word(1'b0, 8'h77, 1'b0);
    word(1'b0, 8'h88, 1'b0);
    #1 chk("stall_ready", {31'd0, bus.in_ready}, 32'h0);
    word(1'b0, 8'h88, 1'b0);
    chk("held_frame", bus.out_d, 32'h44332211);
    word(1'b0, 8'h88, 1'b1);
    chk("frame2", bus.out_d, 32'h88776655);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // Words before any marker are dropped silently.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    word(1'b0, 8'hAA, 1'b1);
    word(1'b0, 8'hBB, 1'b1);
    word(1'b1, 8'h01, 1'b1); word(1'b0, 8'h02, 1'b1);
    word(1'b0, 8'h03, 1'b1); word(1'b0, 8'h04, 1'b1);
    chk("after_drop", bus.out_d, 32'h04030201);

    // Resync on an early marker.
    word(1'b1, 8'h11, 1'b1); word(1'b0, 8'h22, 1'b1);
    word(1'b1, 8'h99, 1'b1);
    chk("resync_err", {31'd0, bus.sync_err}, 32'h1);
    word(1'b0, 8'h33, 1'b1); word(1'b0, 8'h44, 1'b1); word(1'b0, 8'h55, 1'b1);
    chk("resync_frame", bus.out_d, 32'h55443399);

    // Missing marker after a frame sends it back to hunting.
    word(1'b0, 8'h77, 1'b1);
    chk("nosof_err", {31'd0, bus.sync_err}, 32'h1);
    word(1'b0, 8'h78, 1'b1);
    word(1'b1, 8'hA1, 1'b1); word(1'b0, 8'hA2, 1'b1);
    word(1'b0, 8'hA3, 1'b0); word(1'b0, 8'hA4, 1'b0);
    chk("rehunt_frame", bus.out_d, 32'hA4A3A2A1);

    // Reset mid-frame with a pending frame.
    word(1'b1, 8'hC1, 1'b0); word(1'b0, 8'hC2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_mid_out", bus.out_d, 32'h0);
    word(1'b0, 8'hC3, 1'b1);
    word(1'b1, 8'hD1, 1'b1); word(1'b0, 8'hD2, 1'b1);
    word(1'b0, 8'hD3, 1'b1); word(1'b0, 8'hD4, 1'b1);
    chk("post_rst_frame", bus.out_d, 32'hD4D3D2D1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, v, s, fr;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 99) < 80);
      if (!m_in_frame || m_part.size() == 0) s = ($urandom_range(0, 99) < 85);
      else s = ($urandom_range(0, 99) < 6);
      fr = ($urandom_range(0, 99) < 65);
      cycle(r, v, s, W'($urandom), fr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
